mem_responder: RTL and testbench



---
 rtl/mem_resp_pkg.sv | 15 +
 rtl/mem_responder_if.sv | 23 ++
 rtl/mem_responder_lane_merge.sv | 24 ++
 rtl/mem_responder.sv | 119 +++++++++++
 tb/tb_mem_responder.sv | 149 ++++++++++++++
 5 files changed

// File: rtl/mem_resp_pkg.sv
// Shared size codes and FSM state encoding for the memory responder.
package mem_resp_pkg;

   localparam logic [1:0] SZ_WORD = 2'b00;
   localparam logic [1:0] SZ_HALF = 2'b01;
   localparam logic [1:0] SZ_BYTE = 2'b10;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      RD     = 2'd1,
      RMW_RD = 2'd2,
      RMW_WR = 2'd3
   } state_t;

endpackage

// File: rtl/mem_responder_if.sv
// CPU memory port bundle: request from the datapath, data/handshake back from memory.
interface mem_responder_if;

   logic [31:0] Address;
   logic        Rd;
   logic        Wr;
   logic [1:0]  Size;
   logic [31:0] Datain;
   logic [31:0] Dataout;
   logic        Ready;
   logic        Error;

   modport master (
      output Address, Rd, Wr, Size, Datain,
      input  Dataout, Ready, Error
   );

   modport slave (
      input  Address, Rd, Wr, Size, Datain,
      output Dataout, Ready, Error
   );

endinterface

// File: rtl/mem_responder_lane_merge.sv
// Replaces the addressed half/byte lane of a stored word with right-justified write data.
module mem_lane_merge
   import mem_resp_pkg::*;
(
   input  logic [31:0] old_word,
   input  logic [31:0] data,
   input  logic [1:0]  size,
   input  logic [1:0]  lane,
   output logic [31:0] merged
);

   always_comb begin
      merged = old_word;
      case (size)
         SZ_HALF: begin
            if (lane[1]) merged[31:16] = data[15:0];
            else         merged[15:0]  = data[15:0];
         end
         SZ_BYTE: merged[{lane, 3'b000} +: 8] = data[7:0];
         default: ;
      endcase
   end

endmodule

// File: rtl/mem_responder.sv
// Handshaked word store: 1-cycle reads, zero-wait word writes, 2-cycle read-modify-write
// for half/byte writes. Bad requests pulse Error and leave state untouched.
module mem_responder
   import mem_resp_pkg::*;
#(
   parameter int DEPTH  = 256,
   parameter int ADDR_W = $clog2(DEPTH)
)(
   input  logic            clk,
   input  logic            reset,
   mem_responder_if.slave  bus
);

   logic [31:0]       mem [DEPTH];
   state_t            state, state_nx;

   logic [ADDR_W-1:0] idx, idx_q, mem_widx;
   logic [1:0]        lane_q, size_q;
   logic [31:0]       data_q, merge_q, merged, dout_q, mem_wdata;
   logic              oor, misalign, bad_size, oor_q, err_q;
   logic              latch_req, load_merge, dout_ld, mem_we, err_nx;

   assign idx      = bus.Address[ADDR_W+1:2];
   assign oor      = |bus.Address[31:ADDR_W+2];
   assign misalign = ((bus.Size == SZ_WORD) && (bus.Address[1:0] != 2'b00)) ||
                     ((bus.Size == SZ_HALF) && bus.Address[0]);
   assign bad_size = (bus.Size == 2'b11);

   assign bus.Ready   = (state == IDLE);
   assign bus.Dataout = dout_q;
   assign bus.Error   = err_q;

   mem_lane_merge u_merge (
      .old_word (merge_q),
      .data     (data_q),
      .size     (size_q),
      .lane     (lane_q),
      .merged   (merged)
   );

   always_ff @(posedge clk) begin
      if (!reset) state <= IDLE;
      else        state <= state_nx;
   end

   always_comb begin
      state_nx   = state;
      latch_req  = 1'b0;
      load_merge = 1'b0;
      dout_ld    = 1'b0;
      mem_we     = 1'b0;
      mem_widx   = idx;
      mem_wdata  = bus.Datain;
      err_nx     = 1'b0;
      case (state)
         IDLE: begin
            // Wr takes priority; a simultaneous Rd is simply dropped.
            if (bus.Wr) begin
               if (oor || misalign || bad_size) err_nx = 1'b1;
               else if (bus.Size == SZ_WORD)    mem_we = 1'b1;
               else begin
                  latch_req = 1'b1;
                  state_nx  = RMW_RD;
               end
            end else if (bus.Rd) begin
               latch_req = 1'b1;
               state_nx  = RD;
            end
         end
         RD: begin
            dout_ld  = 1'b1;
            err_nx   = oor_q;
            state_nx = IDLE;
         end
         RMW_RD: begin
            load_merge = 1'b1;
            state_nx   = RMW_WR;
         end
         RMW_WR: begin
            mem_we    = 1'b1;
            mem_widx  = idx_q;
            mem_wdata = merged;
            state_nx  = IDLE;
         end
         default: state_nx = IDLE;
      endcase
      // Reset aborts whatever is in flight, including the final RMW write.
      if (!reset) begin
         latch_req  = 1'b0;
         load_merge = 1'b0;
         dout_ld    = 1'b0;
         mem_we     = 1'b0;
         err_nx     = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         dout_q <= '0;
         err_q  <= 1'b0;
      end else begin
         err_q <= err_nx;
         if (dout_ld) dout_q <= oor_q ? 32'h0 : mem[idx_q];
      end
      if (latch_req) begin
         idx_q  <= idx;
         lane_q <= bus.Address[1:0];
         size_q <= bus.Size;
         data_q <= bus.Datain;
         oor_q  <= oor;
      end
      if (load_merge) merge_q <= mem[idx_q];
   end

   always_ff @(posedge clk) begin
      if (mem_we) mem[mem_widx] <= mem_wdata;
   end

endmodule

// File: tb/tb_mem_responder.sv
// Directed bench for mem_responder: expected read data queued at issue, popped on completion.
module tb_mem_responder;
   import mem_resp_pkg::*;

   logic        clk   = 1'b0;
   logic        reset = 1'b0;
   int          checks   = 0;
   int          failures = 0;
   logic [31:0] sb[$];
   logic [31:0] dout_exp = 32'h0;

   always #5 clk = ~clk;

   mem_responder_if bus();

   mem_responder #(.DEPTH(256), .ADDR_W(8)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus.slave)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // One request; counts Ready-low cycles, then checks busy length, Error, Dataout.
   task automatic issue(input logic rd, input logic wr, input logic [1:0] sz,
                        input logic [31:0] addr, input logic [31:0] data,
                        input int exp_busy, input logic exp_err, input string tag);
      int n = 0;
      @(negedge clk);
      bus.Rd = rd; bus.Wr = wr; bus.Size = sz; bus.Address = addr; bus.Datain = data;
      @(posedge clk); #1;
      bus.Rd = 1'b0; bus.Wr = 1'b0;
      while (!bus.Ready && n < 8) begin
         @(posedge clk); #1;
         n++;
      end
      chk({tag, "/busy"}, n, exp_busy);
      chk({tag, "/err"}, {31'b0, bus.Error}, {31'b0, exp_err});
      if (rd && !wr) begin
         if (sb.size() == 0) chk({tag, "/sb_empty"}, 32'd0, 32'd1);
         else dout_exp = sb.pop_front();
      end
      chk({tag, "/dout"}, bus.Dataout, dout_exp);
      if (exp_err) begin
         @(posedge clk); #1;
         chk({tag, "/errclr"}, {31'b0, bus.Error}, 32'd0);
      end
   endtask

   task automatic rd(input logic [31:0] addr, input logic [31:0] exp, input logic exp_err,
                     input string tag);
      sb.push_back(exp);
      issue(1'b1, 1'b0, SZ_WORD, addr, 32'h0, 1, exp_err, tag);
   endtask

   task automatic wr(input logic [1:0] sz, input logic [31:0] addr, input logic [31:0] data,
                     input int exp_busy, input logic exp_err, input string tag);
      issue(1'b0, 1'b1, sz, addr, data, exp_busy, exp_err, tag);
   endtask

   // Starts a byte write, then asserts reset at edge E1 (at_e2=0) or E2 (at_e2=1).
   task automatic rmw_reset(input logic at_e2, input string tag);
      @(negedge clk);
      bus.Wr = 1'b1; bus.Size = SZ_BYTE; bus.Address = 32'h4; bus.Datain = 32'h77;
      @(posedge clk); #1;
      bus.Wr = 1'b0;
      chk({tag, "/busy0"}, {31'b0, bus.Ready}, 32'd0);
      if (at_e2) begin
         @(posedge clk); #1;
      end
      @(negedge clk); reset = 1'b0;
      @(posedge clk); #1;
      chk({tag, "/ready"}, {31'b0, bus.Ready}, 32'd1);
      chk({tag, "/dout"},  bus.Dataout, 32'h0);
      chk({tag, "/err"},   {31'b0, bus.Error}, 32'd0);
      dout_exp = 32'h0;
      @(negedge clk); reset = 1'b1;
   endtask

   initial begin
      bus.Rd = 1'b0; bus.Wr = 1'b0; bus.Size = SZ_WORD; bus.Address = '0; bus.Datain = '0;
      repeat (2) @(posedge clk);
      #1;
      chk("rst/ready", {31'b0, bus.Ready}, 32'd1);
      chk("rst/dout",  bus.Dataout, 32'h0);
      chk("rst/err",   {31'b0, bus.Error}, 32'd0);
      @(negedge clk); reset = 1'b1;

      wr(SZ_WORD, 32'h004, 32'h11223344, 0, 1'b0, "wword4");
      rd(32'h004, 32'h11223344, 1'b0, "rd4a");
      wr(SZ_BYTE, 32'h005, 32'h000000AB, 2, 1'b0, "wbyte5");
      rd(32'h004, 32'h1122AB44, 1'b0, "rd4b");
      wr(SZ_WORD, 32'h004, 32'h11223344, 0, 1'b0, "wword4b");
      wr(SZ_HALF, 32'h006, 32'h0000BEEF, 2, 1'b0, "whalf6");
      rd(32'h004, 32'hBEEF3344, 1'b0, "rd4c");

      wr(SZ_WORD, 32'h000, 32'hA5A5A5A5, 0, 1'b0, "wword0");
      wr(SZ_HALF, 32'h003, 32'h00001234, 0, 1'b1, "mis_half3");
      wr(SZ_WORD, 32'h002, 32'h55555555, 0, 1'b1, "mis_word2");
      wr(2'b11,   32'h000, 32'h66666666, 0, 1'b1, "rsv_size");
      wr(SZ_WORD, 32'h400, 32'h77777777, 0, 1'b1, "oor_write");
      rd(32'h000, 32'hA5A5A5A5, 1'b0, "rd0");

      rd(32'h400, 32'h00000000, 1'b1, "oor_read");

      rd(32'h004, 32'hBEEF3344, 1'b0, "rd4d");
      rmw_reset(1'b0, "rst_e1");
      rd(32'h004, 32'hBEEF3344, 1'b0, "rd4e");
      rmw_reset(1'b1, "rst_e2");
      rd(32'h004, 32'hBEEF3344, 1'b0, "rd4f");

      issue(1'b1, 1'b1, SZ_WORD, 32'h008, 32'hCAFEF00D, 0, 1'b0, "rdwr8");
      rd(32'h008, 32'hCAFEF00D, 1'b0, "rd8");

      wr(SZ_WORD, 32'h010, 32'h12345678, 0, 1'b0, "wword10");
      wr(SZ_WORD, 32'h014, 32'h5555AAAA, 0, 1'b0, "wword14");
      wr(SZ_BYTE, 32'h013, 32'h000000CD, 2, 1'b0, "wbyte13");
      wr(SZ_BYTE, 32'h010, 32'hFFFFFF01, 2, 1'b0, "wbyte10");

      // A write held during the read's busy cycle must be ignored.
      @(negedge clk);
      bus.Rd = 1'b1; bus.Size = SZ_WORD; bus.Address = 32'h010;
      @(posedge clk); #1;
      bus.Rd = 1'b0; bus.Wr = 1'b1; bus.Address = 32'h014; bus.Datain = 32'hDEAD0000;
      @(posedge clk); #1;
      bus.Wr = 1'b0;
      chk("busy_ign/ready", {31'b0, bus.Ready}, 32'd1);
      chk("busy_ign/dout",  bus.Dataout, 32'hCD345601);
      dout_exp = 32'hCD345601;
      rd(32'h014, 32'h5555AAAA, 1'b0, "rd14");

      chk("sb/drained", sb.size(), 32'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

endmodule
